// File: rtl/fetch_pkg.sv
// Shared widths and the redirect request encoding used between decode and fetch.
package fetch_pkg;

  localparam int ADDR_W   = 12;
  localparam int INSTR_W  = 19;
  localparam int OFFSET_W = 8;

  typedef enum logic [2:0] {
    NONE   = 3'd0,
    BRANCH = 3'd1,
    JUMP   = 3'd2,
    CALL   = 3'd3,
    RET    = 3'd4
  } redirect_t;

  // Unused encodings from decode collapse to NONE so they can never move the PC.
  function automatic redirect_t decode_redirect(input logic [2:0] raw);
    if (raw <= 3'd4) return redirect_t'(raw);
    return NONE;
  endfunction

endpackage

// File: rtl/return_stack.sv
// Hardware return-address LIFO. Full pushes and empty pops are ignored;
// the caller owns overflow/underflow reporting.
module return_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  // sp counts occupied entries, so it needs one bit beyond the index width.
  logic [PTR_W:0]   sp;
  logic [PTR_W:0]   sp_m1;
  logic [WIDTH-1:0] mem [DEPTH];

  assign full  = (sp == (PTR_W+1)'(DEPTH));
  assign empty = (sp == '0);
  assign sp_m1 = sp - 1'b1;
  assign top   = mem[sp_m1[PTR_W-1:0]];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; sp==0 already marks every entry dead.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp[PTR_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, fills the IF/ID register, and applies decode redirects
// (branch/jump/call/return) using an internal return-address stack.
module instruction_fetch_unit #(
  parameter int              ADDR_W      = fetch_pkg::ADDR_W,
  parameter int              INSTR_W     = fetch_pkg::INSTR_W,
  parameter int              OFFSET_W    = fetch_pkg::OFFSET_W,
  parameter int              STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic [2:0]          redirect,
  input  logic [OFFSET_W-1:0] branch_offset,
  input  logic [ADDR_W-1:0]   jump_target,
  output logic [ADDR_W-1:0]   imem_address,
  input  logic [INSTR_W-1:0]  imem_instruction,
  output logic [INSTR_W-1:0]  id_instruction,
  output logic [ADDR_W-1:0]   id_pc,
  output logic                id_valid,
  output logic                stack_overflow,
  output logic                stack_underflow
);

  import fetch_pkg::*;

  logic [ADDR_W-1:0] pc;
  redirect_t         req;
  logic              fire;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] offset_ext;
  logic [ADDR_W-1:0] target;
  logic              rs_push;
  logic              rs_pop;
  logic [ADDR_W-1:0] rs_top;
  logic              rs_full;
  logic              rs_empty;
  logic              set_ovf;
  logic              set_unf;

  assign imem_address = pc;
  assign req          = decode_redirect(redirect);
  // A redirect only counts against a live decode slot and while the pipe is moving.
  assign fire         = !stall && id_valid && (req != NONE);
  assign seq_pc       = id_pc + 1'b1;
  assign offset_ext   = {{(ADDR_W-OFFSET_W){branch_offset[OFFSET_W-1]}}, branch_offset};

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    target  = seq_pc;
    rs_push = 1'b0;
    rs_pop  = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    case (req)
      BRANCH: target = seq_pc + offset_ext;
      JUMP:   target = jump_target;
      CALL: begin
        target  = jump_target;
        rs_push = fire && !rs_full;
        set_ovf = rs_full;
      end
      RET: begin
        if (rs_empty) begin
          set_unf = 1'b1;
        end else begin
          target = rs_top;
          rs_pop = fire;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc              <= RESET_PC;
      id_instruction  <= '0;
      id_pc           <= '0;
      id_valid        <= 1'b0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else if (!stall) begin
      // The IF/ID payload always loads; on a redirect id_valid squashes it.
      id_instruction <= imem_instruction;
      id_pc          <= pc;
      if (fire) begin
        pc              <= target;
        id_valid        <= 1'b0;
        stack_overflow  <= stack_overflow | set_ovf;
        stack_underflow <= stack_underflow | set_unf;
      end else begin
        pc       <= pc + 1'b1;
        id_valid <= 1'b1;
      end
    end
  end

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_return_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (rs_push),
    .pop       (rs_pop),
    .push_data (seq_pc),
    .top       (rs_top),
    .full      (rs_full),
    .empty     (rs_empty)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a queue-based fetch model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  redirect = 3'd0;
  logic [7:0]  branch_offset = 8'd0;
  logic [11:0] jump_target = 12'd0;
  logic [11:0] imem_address;
  logic [18:0] imem_instruction;
  logic [18:0] id_instruction;
  logic [11:0] id_pc;
  logic        id_valid;
  logic        stack_overflow;
  logic        stack_underflow;

  logic [18:0] mem [4096];
  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // model state
  logic [11:0] m_pc;
  logic [18:0] m_id_instr;
  logic [11:0] m_id_pc;
  logic        m_id_valid;
  logic        m_ovf;
  logic        m_unf;
  int          m_stack[$];

  instruction_fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .redirect         (redirect),
    .branch_offset    (branch_offset),
    .jump_target      (jump_target),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .id_instruction   (id_instruction),
    .id_pc            (id_pc),
    .id_valid         (id_valid),
    .stack_overflow   (stack_overflow),
    .stack_underflow  (stack_underflow)
  );

  assign imem_instruction = mem[imem_address];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the PC as an integer mod 4096 and the stack as a queue.
  always @(posedge clk or posedge rst) begin : model
    int t;
    int seq;
    if (rst) begin
      m_pc       <= 12'd0;
      m_id_instr <= 19'd0;
      m_id_pc    <= 12'd0;
      m_id_valid <= 1'b0;
      m_ovf      <= 1'b0;
      m_unf      <= 1'b0;
      m_stack.delete();
    end else if (!stall) begin
      if (m_id_valid && redirect >= 3'd1 && redirect <= 3'd4) begin
        seq = (int'(m_id_pc) + 1) % 4096;
        t = seq;
        case (redirect)
          3'd1: t = (int'(m_id_pc) + 1 + int'($signed(branch_offset)) + 4096) % 4096;
          3'd2: t = int'(jump_target);
          3'd3: begin
            t = int'(jump_target);
            if (m_stack.size() < 8) m_stack.push_back(seq);
            else m_ovf <= 1'b1;
          end
          default: begin
            if (m_stack.size() > 0) t = m_stack.pop_back();
            else m_unf <= 1'b1;
          end
        endcase
        m_pc       <= 12'(t);
        m_id_valid <= 1'b0;
      end else begin
        m_id_instr <= mem[m_pc];
        m_id_pc    <= m_pc;
        m_id_valid <= 1'b1;
        m_pc       <= 12'((int'(m_pc) + 1) % 4096);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("imem_address", 32'(imem_address), 32'(m_pc));
      check("id_valid", 32'(id_valid), 32'(m_id_valid));
      check("stack_overflow", 32'(stack_overflow), 32'(m_ovf));
      check("stack_underflow", 32'(stack_underflow), 32'(m_unf));
      if (m_id_valid) begin
        check("id_pc", 32'(id_pc), 32'(m_id_pc));
        check("id_instruction", 32'(id_instruction), 32'(m_id_instr));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic redir(input logic [2:0] r, input logic [11:0] jt, input logic [7:0] off);
    redirect      = r;
    jump_target   = jt;
    branch_offset = off;
    cyc();
    redirect = 3'd0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 19'(i * 2731 + 17) ^ 19'(i << 5);

    #1 rst = 1'b1;
    #1;
    check("rst_addr", 32'(imem_address), 32'd0);
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_id_pc", 32'(id_pc), 32'd0);
    check("rst_id_instr", 32'(id_instruction), 32'd0);
    check("rst_flags", 32'({stack_overflow, stack_underflow}), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    cmp_en = 1'b1;
    check("fetch_addr0", 32'(imem_address), 32'd0);

    // free run from reset
    for (int k = 1; k <= 3; k++) begin
      cyc();
      check("fetch_addr", 32'(imem_address), 32'(k));
      check("fetch_id_pc", 32'(id_pc), 32'(k - 1));
      check("fetch_valid", 32'(id_valid), 32'd1);
      check("fetch_instr", 32'(id_instruction), 32'(mem[k-1]));
    end

    // stall at PC=5
    cyc(); cyc();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("stall_addr", 32'(imem_address), 32'd5);
      check("stall_id_pc", 32'(id_pc), 32'd4);
    end
    stall = 1'b0;
    cyc();
    check("unstall_addr", 32'(imem_address), 32'd6);

    // backward branch at id_pc=10
    repeat (5) cyc();
    check("pre_branch_id_pc", 32'(id_pc), 32'd10);
    redir(3'd1, 12'd0, 8'hFC);
    check("branch_addr", 32'(imem_address), 32'd7);
    check("branch_squash", 32'(id_valid), 32'd0);
    cyc();
    check("branch_land_id_pc", 32'(id_pc), 32'd7);
    check("branch_land_valid", 32'(id_valid), 32'd1);

    // out-of-enum redirect behaves like NONE
    redir(3'd7, 12'd999, 8'd50);
    check("bad_redir_addr", 32'(imem_address), 32'd9);
    check("bad_redir_valid", 32'(id_valid), 32'd1);

    // branch wrap: +3 at id_pc=4094 -> 2
    redir(3'd2, 12'd4094, 8'd0);
    check("jump_addr", 32'(imem_address), 32'd4094);
    cyc();
    redir(3'd1, 12'd0, 8'd3);
    check("branch_wrap_addr", 32'(imem_address), 32'd2);
    cyc();
    redir(3'd2, 12'd4095, 8'd0);
    cyc();
    check("pc_wrap_addr", 32'(imem_address), 32'd0);
    check("pc_wrap_id_pc", 32'(id_pc), 32'd4095);
    cyc();

    // call / return
    redir(3'd2, 12'd20, 8'd0);
    cyc();
    redir(3'd3, 12'd100, 8'd0);
    check("call_addr", 32'(imem_address), 32'd100);
    repeat (6) cyc();
    check("pre_ret_id_pc", 32'(id_pc), 32'd105);
    redir(3'd4, 12'd0, 8'd0);
    check("ret_addr", 32'(imem_address), 32'd21);
    check("ret_no_unf", 32'(stack_underflow), 32'd0);

    // return on empty stack
    cyc();
    redir(3'd2, 12'd30, 8'd0);
    cyc();
    redir(3'd4, 12'd0, 8'd0);
    check("unf_addr", 32'(imem_address), 32'd31);
    check("unf_set", 32'(stack_underflow), 32'd1);
    repeat (3) cyc();
    check("unf_sticky", 32'(stack_underflow), 32'd1);

    // nine nested calls, then unwind
    for (int i = 0; i < 9; i++) begin
      cyc();
      redir(3'd3, 12'(200 + 16 * i), 8'd0);
      if (i == 7) check("ovf_clear_at_8", 32'(stack_overflow), 32'd0);
    end
    check("ovf_set", 32'(stack_overflow), 32'd1);
    check("ovf_jump_addr", 32'(imem_address), 32'd328);
    cyc();
    redir(3'd4, 12'd0, 8'd0);
    check("ovf_first_ret", 32'(imem_address), 32'd297);
    for (int i = 0; i < 8; i++) begin
      cyc();
      redir(3'd4, 12'd0, 8'd0);
    end

    // async reset during stall + call request
    cyc();
    stall       = 1'b1;
    redirect    = 3'd3;
    jump_target = 12'd500;
    #2 rst = 1'b1;
    #1;
    check("async_rst_addr", 32'(imem_address), 32'd0);
    check("async_rst_valid", 32'(id_valid), 32'd0);
    check("async_rst_flags", 32'({stack_overflow, stack_underflow}), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    stall    = 1'b0;
    redirect = 3'd0;
    check("post_rst_addr", 32'(imem_address), 32'd0);
    cyc();
    check("post_rst_id_pc", 32'(id_pc), 32'd0);
    check("post_rst_instr", 32'(id_instruction), 32'(mem[0]));
    check("post_rst_next", 32'(imem_address), 32'd1);
    cyc();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
